// File: rtl/ama_riscv_operand_stage.sv
// ID-side operand stage: resolves RAW hazards by EX/WB forwarding, inserts load-use bubbles and
// registers resolved operands into ID/EX. Define AMA_RISCV_OPSTAGE_PERF_EN for stall/fwd counters.
module ama_riscv_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_rd_we,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [ADDR_W-1:0] ex_rd_o,
`ifdef AMA_RISCV_OPSTAGE_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt,
`endif
  output logic              ex_rd_we_o
);

  if (REG_NUM > (1 << ADDR_W)) begin : g_cfg_check
    $error("REG_NUM does not fit in ADDR_W address bits");
  end

  logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic              load_use, load_en;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_op_a_q, ex_op_a_d;
  logic [DATA_W-1:0] ex_op_b_q, ex_op_b_d;
  logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rd_we_q, ex_rd_we_d;

  // A nonzero source match implies a nonzero rd, so x0 is never a forwarding source.
  always_comb begin
    ex_hit_a = (id_rs1 != '0) && ex_rd_we && !ex_is_load && (ex_rd == id_rs1);
    ex_hit_b = (id_rs2 != '0) && ex_rd_we && !ex_is_load && (ex_rd == id_rs2);
    wb_hit_a = (id_rs1 != '0) && wb_we && (wb_rd == id_rs1);
    wb_hit_b = (id_rs2 != '0) && wb_we && (wb_rd == id_rs2);

    if (id_rs1 == '0)  op_a = '0;
    else if (ex_hit_a) op_a = ex_result;
    else if (wb_hit_a) op_a = wb_data;
    else               op_a = rf_data_a;

    if (id_rs2 == '0)  op_b = '0;
    else if (ex_hit_b) op_b = ex_result;
    else if (wb_hit_b) op_b = wb_data;
    else               op_b = rf_data_b;
  end

  always_comb begin
    load_use = id_valid && ex_rd_we && ex_is_load && (ex_rd != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    stall_id = !rst && !flush && (hold || load_use);
    load_en  = !flush && !hold && !load_use;
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_a_d  = ex_op_a_q;
    ex_op_b_d  = ex_op_b_q;
    ex_rd_d    = ex_rd_q;
    ex_rd_we_d = ex_rd_we_q;
    if (rst || flush || (!hold && load_use)) begin
      ex_valid_d = 1'b0;
      ex_op_a_d  = '0;
      ex_op_b_d  = '0;
      ex_rd_d    = '0;
      ex_rd_we_d = 1'b0;
    end else if (!hold) begin
      ex_valid_d = id_valid;
      ex_op_a_d  = op_a;
      ex_op_b_d  = op_b;
      ex_rd_d    = id_rd;
      ex_rd_we_d = id_valid && id_rd_we;
    end
  end

  always_ff @(posedge clk) begin
    ex_valid_q <= ex_valid_d;
    ex_op_a_q  <= ex_op_a_d;
    ex_op_b_q  <= ex_op_b_d;
    ex_rd_q    <= ex_rd_d;
    ex_rd_we_q <= ex_rd_we_d;
  end

  assign ex_valid   = ex_valid_q;
  assign ex_op_a    = ex_op_a_q;
  assign ex_op_b    = ex_op_b_q;
  assign ex_rd_o    = ex_rd_q;
  assign ex_rd_we_o = ex_rd_we_q;

`ifdef AMA_RISCV_OPSTAGE_PERF_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_fwd_cnt_q, perf_fwd_cnt_d;
  logic        stall_inc, fwd_inc;

  always_comb begin
    stall_inc = load_use && !hold && !flush;
    fwd_inc   = load_en && id_valid && (ex_hit_a || ex_hit_b || wb_hit_a || wb_hit_b);
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_fwd_cnt_d   = perf_fwd_cnt_q;
    if (rst) begin
      perf_stall_cnt_d = '0;
      perf_fwd_cnt_d   = '0;
    end else begin
      if (stall_inc && (perf_stall_cnt_q != '1)) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
      if (fwd_inc && (perf_fwd_cnt_q != '1))     perf_fwd_cnt_d   = perf_fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    perf_stall_cnt_q <= perf_stall_cnt_d;
    perf_fwd_cnt_q   <= perf_fwd_cnt_d;
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_fwd_cnt   = perf_fwd_cnt_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_ama_riscv_operand_stage.sv
// Directed self-checking bench for ama_riscv_operand_stage; perf checks need
// AMA_RISCV_OPSTAGE_PERF_EN defined.
module tb_ama_riscv_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs1_used, id_rs2_used, id_rd_we;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
  logic [DW-1:0] rf_data_a, rf_data_b, ex_result, wb_data;
  logic          ex_rd_we, ex_is_load, wb_we, flush, hold;
  logic          stall_id, ex_valid, ex_rd_we_o;
  logic [DW-1:0] ex_op_a, ex_op_b;
  logic [AW-1:0] ex_rd_o;
`ifdef AMA_RISCV_OPSTAGE_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ama_riscv_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_result(ex_result), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_data(wb_data), .flush(flush), .hold(hold), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd_o(ex_rd_o),
`ifdef AMA_RISCV_OPSTAGE_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
    .ex_rd_we_o(ex_rd_we_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; rf_data_a = 0; rf_data_b = 0; ex_rd = 0; ex_rd_we = 0;
    ex_is_load = 0; ex_result = 0; wb_rd = 0; wb_we = 0; wb_data = 0; flush = 0; hold = 0;
  endtask

  task automatic instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] rd);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = 1; id_rs2_used = 1;
    rf_data_a = a; rf_data_b = b; id_rd = rd; id_rd_we = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = 1; id_valid = 1'($urandom); id_rs1 = AW'($urandom); id_rs2 = AW'($urandom);
      id_rs1_used = 1; id_rs2_used = 1; id_rd = AW'($urandom); id_rd_we = 1;
      rf_data_a = $urandom; rf_data_b = $urandom; ex_rd = id_rs1; ex_rd_we = 1;
      ex_is_load = 1; ex_result = $urandom; wb_rd = AW'($urandom); wb_we = 1'($urandom);
      wb_data = $urandom; flush = 0; hold = 1'($urandom);
      #1;
      checks++;
      if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_id); end
      step();
      checks++;
      if ({ex_valid, ex_rd_we_o, ex_op_a, ex_op_b, ex_rd_o} !== '0) begin
        errors++;
        $display("FAIL reset_state got v=%b we=%b a=%h b=%h rd=%0d exp all 0",
                 ex_valid, ex_rd_we_o, ex_op_a, ex_op_b, ex_rd_o);
      end
    end
    idle();
    instr(5'd1, 5'd2, 32'h100, 32'h200, 5'd9);
    step();
    checks++;
    if ({ex_valid, ex_rd_we_o, ex_op_a, ex_op_b, ex_rd_o} !== {2'b11, 32'h100, 32'h200, 5'd9}) begin
      errors++;
      $display("FAIL post_reset got v=%b we=%b a=%h b=%h rd=%0d exp 1 1 100 200 9",
               ex_valid, ex_rd_we_o, ex_op_a, ex_op_b, ex_rd_o);
    end
  endtask

  task automatic test_no_hazard();
    idle();
    instr(5'd5, 5'd6, 32'h11, 32'h22, 5'd8);
    ex_rd = 5'd9; ex_rd_we = 1; ex_result = 32'hEEEE; wb_rd = 5'd10; wb_we = 1; wb_data = 32'hFFFF;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL nohaz_stall got %b exp 0", stall_id); end
    step();
    checks++;
    if ({ex_valid, ex_op_a, ex_op_b} !== {1'b1, 32'h11, 32'h22}) begin
      errors++;
      $display("FAIL no_hazard got v=%b a=%h b=%h exp 1 11 22", ex_valid, ex_op_a, ex_op_b);
    end
  endtask

  task automatic test_forward();
    idle();
    instr(5'd7, 5'd7, 32'h1, 32'h2, 5'd4);
    ex_rd = 5'd7; ex_rd_we = 1; ex_result = 32'hAAAA; wb_rd = 5'd7; wb_we = 1; wb_data = 32'hBBBB;
    step();
    checks++;
    if ({ex_op_a, ex_op_b} !== {32'hAAAA, 32'hAAAA}) begin
      errors++; $display("FAIL fwd_ex_over_wb got a=%h b=%h exp AAAA AAAA", ex_op_a, ex_op_b);
    end
    ex_rd_we = 0;
    step();
    checks++;
    if ({ex_op_a, ex_op_b} !== {32'hBBBB, 32'hBBBB}) begin
      errors++; $display("FAIL fwd_wb got a=%h b=%h exp BBBB BBBB", ex_op_a, ex_op_b);
    end
    // rs1 from EX only, rs2 from WB only
    id_rs2 = 5'd12; wb_rd = 5'd12; ex_rd_we = 1;
    step();
    checks++;
    if ({ex_op_a, ex_op_b} !== {32'hAAAA, 32'hBBBB}) begin
      errors++; $display("FAIL fwd_split got a=%h b=%h exp AAAA BBBB", ex_op_a, ex_op_b);
    end
    instr(5'd0, 5'd0, 32'h77, 32'h88, 5'd4);
    ex_rd = 5'd0; ex_rd_we = 1; ex_result = 32'h5; wb_rd = 5'd0; wb_we = 1; wb_data = 32'h9;
    step();
    checks++;
    if ({ex_valid, ex_op_a, ex_op_b} !== {1'b1, 64'h0}) begin
      errors++; $display("FAIL x0_zero got v=%b a=%h b=%h exp 1 0 0", ex_valid, ex_op_a, ex_op_b);
    end
  endtask

  task automatic test_load_use();
    idle();
    instr(5'd1, 5'd3, 32'h1111, 32'h5555, 5'd4);
    ex_rd = 5'd3; ex_rd_we = 1; ex_is_load = 1; ex_result = 32'h9999;
    #1;
    checks++;
    if (stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall_id); end
    step();
    checks++;
    if ({ex_valid, ex_rd_we_o, ex_op_b} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL lu_bubble got v=%b we=%b b=%h exp 0 0 0", ex_valid, ex_rd_we_o, ex_op_b);
    end
    ex_rd = 0; ex_rd_we = 0; ex_is_load = 0; wb_rd = 5'd3; wb_we = 1; wb_data = 32'hDEAD;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", stall_id); end
    step();
    checks++;
    if ({ex_valid, ex_op_a, ex_op_b} !== {1'b1, 32'h1111, 32'hDEAD}) begin
      errors++;
      $display("FAIL lu_wb_fwd got v=%b a=%h b=%h exp 1 1111 DEAD", ex_valid, ex_op_a, ex_op_b);
    end
    // invalid ID slot never stalls, and loads a bubble
    idle();
    id_rs1 = 5'd3; id_rs1_used = 1; ex_rd = 5'd3; ex_rd_we = 1; ex_is_load = 1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL lu_invalid got %b exp 0", stall_id); end
    step();
    checks++;
    if ({ex_valid, ex_rd_we_o} !== 2'b00) begin
      errors++; $display("FAIL invalid_bubble got v=%b we=%b exp 0 0", ex_valid, ex_rd_we_o);
    end
  endtask

  task automatic test_hold_flush();
    idle();
    instr(5'd2, 5'd3, 32'h33, 32'h44, 5'd10);
    step();
    instr(5'd4, 5'd5, 32'h99, 32'h98, 5'd11);
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (stall_id !== 1'b1) begin errors++; $display("FAIL hold_stall got %b exp 1", stall_id); end
      step();
      checks++;
      if ({ex_valid, ex_rd_we_o, ex_op_a, ex_op_b, ex_rd_o} !== {2'b11, 32'h33, 32'h44, 5'd10}) begin
        errors++;
        $display("FAIL hold_keep got v=%b we=%b a=%h b=%h rd=%0d exp 1 1 33 44 10",
                 ex_valid, ex_rd_we_o, ex_op_a, ex_op_b, ex_rd_o);
      end
    end
    flush = 1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL hflush_stall got %b exp 0", stall_id); end
    step();
    checks++;
    if ({ex_valid, ex_rd_we_o, ex_op_a, ex_op_b} !== {2'b00, 64'h0}) begin
      errors++;
      $display("FAIL hold_flush got v=%b we=%b a=%h b=%h exp 0 0 0 0",
               ex_valid, ex_rd_we_o, ex_op_a, ex_op_b);
    end
    idle();
    instr(5'd6, 5'd1, 32'h1, 32'h2, 5'd7);
    ex_rd = 5'd6; ex_rd_we = 1; ex_is_load = 1; flush = 1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL luflush_stall got %b exp 0", stall_id); end
    step();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_flush got v=%b exp 0", ex_valid); end
  endtask

  task automatic test_rst_mid_stall();
    idle();
    instr(5'd2, 5'd3, 32'h61, 32'h62, 5'd13);
    step();
    hold = 1;
    #1;
    checks++;
    if (stall_id !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", stall_id); end
    rst = 1;
    #1;
    checks++;
    if (stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall_id); end
    step();
    checks++;
    if ({ex_valid, ex_op_a} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_mid_stall got v=%b a=%h exp 0 0", ex_valid, ex_op_a);
    end
    idle();
  endtask

`ifdef AMA_RISCV_OPSTAGE_PERF_EN
  task automatic lu_event(input logic h);
    idle();
    instr(5'd3, 5'd1, 32'h0, 32'h0, 5'd4);
    ex_rd = 5'd3; ex_rd_we = 1; ex_is_load = 1; hold = h;
    step();
    idle();
    step();
  endtask

  task automatic test_perf();
    idle(); rst = 1; step(); idle();
    checks++;
    if ({perf_stall_cnt, perf_fwd_cnt} !== 64'h0) begin
      errors++; $display("FAIL perf_reset got %h %h exp 0 0", perf_stall_cnt, perf_fwd_cnt);
    end
    lu_event(1'b0);
    lu_event(1'b1);
    lu_event(1'b0);
    checks++;
    if (perf_stall_cnt !== 32'd2) begin
      errors++; $display("FAIL perf_stall got %0d exp 2", perf_stall_cnt);
    end
    instr(5'd8, 5'd1, 32'h0, 32'h0, 5'd4);
    wb_rd = 5'd8; wb_we = 1; wb_data = 32'h12;
    step();
    idle();
    checks++;
    if (perf_fwd_cnt !== 32'd1) begin errors++; $display("FAIL perf_fwd got %0d exp 1", perf_fwd_cnt); end
    force dut.perf_stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall_cnt_q;
    lu_event(1'b0);
    checks++;
    if (perf_stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL perf_sat got %h exp FFFFFFFF", perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    idle();
    #1;
    test_reset();
    test_no_hazard();
    test_forward();
    test_load_use();
    test_hold_flush();
    test_rst_mid_stall();
`ifdef AMA_RISCV_OPSTAGE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
